// File: rtl/alu_issue_ctrl_if.sv
// Bus bundle between alu_issue_ctrl and its surroundings (instruction
// source, register file, ALU, writeback port).
// Handshake: a word transfers on a rising clk edge where iw_valid and
// iw_ready are both high. The source keeps iw_valid high and iw stable
// until that edge. iw_ready never depends on iw_valid. After a transfer the
// controller is busy and iw_ready stays low until it returns to IDLE.
// The master modport is the environment side. The slave modport is the controller.
interface alu_issue_ctrl_if;
  logic        iw_valid;
  logic [31:0] iw;
  logic        iw_ready;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data_in;
  logic [31:0] rs2_data_in;
  logic [31:0] alu_iw;
  logic [31:0] alu_rs1;
  logic [31:0] alu_rs2;
  logic        alu_start;
  logic [31:0] alu_out;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        illegal;
  logic        busy;

  modport slave (
    input  iw_valid, iw, rs1_data_in, rs2_data_in, alu_out,
    output iw_ready, rs1_addr, rs2_addr, alu_iw, alu_rs1, alu_rs2,
           alu_start, wb_en, wb_addr, wb_data, illegal, busy
  );

  modport master (
    output iw_valid, iw, rs1_data_in, rs2_data_in, alu_out,
    input  iw_ready, rs1_addr, rs2_addr, alu_iw, alu_rs1, alu_rs2,
           alu_start, wb_en, wb_addr, wb_data, illegal, busy
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: single-issue sequencer for RV32I OP / OP-IMM words in
// front of a clocked ALU.
// Sequence: IDLE -> READ -> EXEC -> WB -> IDLE. An illegal word takes the
// path IDLE -> ERR -> IDLE instead.
// ALU_LATENCY (1..8) is the ALU latency in cycles. It is measured from the
// edge that samples alu_start high to the edge where alu_out is captured.
// Optional build macro ALU_ISSUE_PERF_EN adds two output ports:
// retired_cnt counts WB states and illegal_cnt counts ERR states.
module alu_issue_ctrl #(
  parameter int ALU_LATENCY = 1
) (
  input  logic             clk,
  input  logic             reset,
  alu_issue_ctrl_if.slave  bus,
  output logic [2:0]       dbg_state_o
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]      retired_cnt,
  output logic [15:0]      illegal_cnt
`endif
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_READ = 3'd1;
  localparam logic [2:0] S_EXEC = 3'd2;
  localparam logic [2:0] S_WB   = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // The counter covers the ALU cycles that follow the alu_start cycle.
  localparam logic [2:0] LAT_M1 = 3'(ALU_LATENCY - 1);

  logic [2:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] iw_q;
  logic [31:0] rs1_q;
  logic [31:0] rs2_q;
  logic        start_q;
  logic [31:0] wb_data_q;
  logic        accept;
  logic        exec_done;

  // OP: funct7 must be 0. The alternate funct7 (0100000) is allowed only for
  // SUB and SRA. OP-IMM: only the shift-immediates constrain iw[31:25].
  function automatic logic is_legal(input logic [31:0] w);
    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok;
    opc = w[6:0];
    f3  = w[14:12];
    f7  = w[31:25];
    ok  = 1'b0;
    case (opc)
      OPC_OP:     ok = (f7 == F7_ZERO) ||
                       ((f7 == F7_ALT) && ((f3 == 3'b000) || (f3 == 3'b101)));
      OPC_OP_IMM: begin
        case (f3)
          3'b001:  ok = (f7 == F7_ZERO);
          3'b101:  ok = (f7 == F7_ZERO) || (f7 == F7_ALT);
          default: ok = 1'b1;
        endcase
      end
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

  assign accept    = (state_q == S_IDLE) && bus.iw_valid;
  // The first EXEC cycle is the alu_start cycle. The countdown begins after it.
  assign exec_done = (state_q == S_EXEC) && !start_q && (cnt_q == 3'd0);

  // Next-state and latency counter logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (bus.iw_valid) state_d = is_legal(bus.iw) ? S_READ : S_ERR;
      S_READ: begin
        state_d = S_EXEC;
        cnt_d   = LAT_M1;
      end
      S_EXEC: begin
        if (!start_q) begin
          if (cnt_q == 3'd0) state_d = S_WB;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      S_WB:    state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State register. Reset discards any instruction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath registers: latched word, operands, start pulse, result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      iw_q      <= 32'd0;
      rs1_q     <= 32'd0;
      rs2_q     <= 32'd0;
      start_q   <= 1'b0;
      wb_data_q <= 32'd0;
    end else begin
      if (accept) iw_q <= bus.iw;
      if (state_q == S_READ) begin
        rs1_q <= bus.rs1_data_in;
        rs2_q <= (iw_q[6:0] == OPC_OP_IMM) ? {{20{iw_q[31]}}, iw_q[31:20]}
                                           : bus.rs2_data_in;
      end
      start_q <= (state_q == S_READ);
      if (exec_done) wb_data_q <= bus.alu_out;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  // Performance counters. Both wrap naturally at their width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_cnt <= 32'd0;
      illegal_cnt <= 16'd0;
    end else begin
      if (state_q == S_WB)  retired_cnt <= retired_cnt + 32'd1;
      if (state_q == S_ERR) illegal_cnt <= illegal_cnt + 16'd1;
    end
  end
`endif

  assign bus.iw_ready  = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.rs1_addr  = iw_q[19:15];
  assign bus.rs2_addr  = iw_q[24:20];
  assign bus.alu_iw    = iw_q;
  assign bus.alu_rs1   = rs1_q;
  assign bus.alu_rs2   = rs2_q;
  assign bus.alu_start = start_q;
  assign bus.wb_addr   = iw_q[11:7];
  assign bus.wb_data   = wb_data_q;
  assign bus.wb_en     = (state_q == S_WB) && (iw_q[11:7] != 5'd0);
  assign bus.illegal   = (state_q == S_ERR);
  assign dbg_state_o   = state_q;

endmodule
